// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor; SM_ADDSUB_ZERO_NORM_EN forces mag=0 results to +0.
// Latency: result valid two edges after input transfer; one transaction per cycle.
// Backpressure: out_ready=0 holds S/OF; up to two transactions buffered, then in_ready drops.
module sm_addsub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             OF,
  output logic             OF_STICKY,
  input  logic             OF_CLR
);

  localparam int MAG_W = WIDTH - 1;

  logic             s_a, s_b, ge;
  logic [MAG_W-1:0] m_a, m_b;

  logic             s1_valid, s2_valid;
  logic             s1_diff, s1_sa, s1_ss;
  logic [MAG_W-1:0] s1_big, s1_small;

  logic             s1_adv, s2_adv;

  logic [MAG_W:0]   sum;
  logic [MAG_W-1:0] s2_mag;
  logic             s2_sign, s2_of;

  assign s_a = A[WIDTH-1];
  assign s_b = B[WIDTH-1] ^ SUB;
  assign m_a = A[MAG_W-1:0];
  assign m_b = B[MAG_W-1:0];
  assign ge  = (m_a >= m_b);

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Operands are pre-swapped so the subtract path never borrows.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_diff  <= s_a ^ s_b;
      s1_sa    <= s_a;
      s1_ss    <= ge ? s_a : s_b;
      s1_big   <= ge ? m_a : m_b;
      s1_small <= ge ? m_b : m_a;
    end
  end

  always_comb begin
    sum     = {1'b0, s1_big} + {1'b0, s1_small};
    s2_mag  = sum[MAG_W-1:0];
    s2_of   = sum[MAG_W];
    s2_sign = s1_sa;
    if (s1_diff) begin
      s2_mag  = s1_big - s1_small;
      s2_of   = 1'b0;
      s2_sign = s1_ss;
    end
`ifdef SM_ADDSUB_ZERO_NORM_EN
    if (s2_mag == '0 && !s2_of) begin
      s2_sign = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      S         <= '0;
      OF        <= 1'b0;
      OF_STICKY <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv) begin
        S  <= {s2_sign, s2_mag};
        OF <= s2_of;
      end
      // Set has priority over a coincident clear.
      if (s2_valid && out_ready && OF) begin
        OF_STICKY <= 1'b1;
      end else if (OF_CLR) begin
        OF_STICKY <= 1'b0;
      end
    end
  end

endmodule
